// File: rtl/multicycle_alu.sv
// Multi-cycle ALU with one operation in flight at a time.
// ADD/SUB/AND/OR/XOR/SLT/SLTU/NOP finish one cycle after accept.
// Shifts advance up to SHIFT_STEP bits per cycle.
// Define MULTICYCLE_ALU_MUL_EN to build the shift-add multiplier (op 11).
// Without that macro, op 11 is treated as an undefined code and returns 0.
// The result is held in DONE until the consumer takes it.
module multicycle_alu #(
   parameter int XLEN       = 32,
   parameter int SHIFT_STEP = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);

   localparam int SHW = $clog2(XLEN);
   // Shift amounts never exceed XLEN-1, so a larger step saturates there.
   localparam logic [SHW-1:0] STEP_C = (SHIFT_STEP >= XLEN) ? SHW'(XLEN - 1) : SHW'(SHIFT_STEP);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SLL  = 4'd6;
   localparam logic [3:0] OP_SRL  = 4'd7;
   localparam logic [3:0] OP_SRA  = 4'd8;
   localparam logic [3:0] OP_SLT  = 4'd9;
   localparam logic [3:0] OP_SLTU = 4'd10;
`ifdef MULTICYCLE_ALU_MUL_EN
   localparam logic [3:0] OP_MUL  = 4'd11;
`endif

`ifdef MULTICYCLE_ALU_MUL_EN
   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL, S_DONE} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
`endif

   state_t              state_q, state_d;
   logic [XLEN-1:0]     res_q, res_d;
   logic [3:0]          op_q, op_d;
   logic [SHW-1:0]      cnt_q, cnt_d;
   logic [SHW-1:0]      amt;
`ifdef MULTICYCLE_ALU_MUL_EN
   logic [XLEN-1:0]     mcand_q, mcand_d;
   logic [XLEN-1:0]     mplier_q, mplier_d;
`endif

   // Single-cycle operations; NOP and undefined codes return zero.
   function automatic logic [XLEN-1:0] alu_single(input logic [3:0] f,
                                                  input logic [XLEN-1:0] x,
                                                  input logic [XLEN-1:0] y);
      logic signed [XLEN-1:0] sx;
      logic signed [XLEN-1:0] sy;
      sx = x;
      sy = y;
      case (f)
         OP_ADD:  return x + y;
         OP_SUB:  return x - y;
         OP_AND:  return x & y;
         OP_OR:   return x | y;
         OP_XOR:  return x ^ y;
         OP_SLT:  return {{(XLEN-1){1'b0}}, (sx < sy)};
         OP_SLTU: return {{(XLEN-1){1'b0}}, (x < y)};
         default: return '0;
      endcase
   endfunction

   // Bits to shift this cycle: the lesser of the step and what remains.
   function automatic logic [SHW-1:0] step_amt(input logic [SHW-1:0] rem);
      return (rem < STEP_C) ? rem : STEP_C;
   endfunction

   // One partial shift; SRA replicates the sign bit, the others fill with zeros.
   function automatic logic [XLEN-1:0] shift_by(input logic [3:0] f,
                                                input logic [XLEN-1:0] v,
                                                input logic [SHW-1:0] s);
      logic signed [XLEN-1:0] sv;
      sv = v;
      case (f)
         OP_SLL:  return v << s;
         OP_SRA:  return $unsigned(sv >>> s);
         default: return v >> s;
      endcase
   endfunction

   // Next-state and datapath update for the FSM.
   always_comb begin
      state_d  = state_q;
      res_d    = res_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      amt      = '0;
`ifdef MULTICYCLE_ALU_MUL_EN
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               op_d = op;
               case (op)
                  OP_SLL, OP_SRL, OP_SRA: begin
                     res_d   = a;
                     cnt_d   = b[SHW-1:0];
                     state_d = (b[SHW-1:0] == '0) ? S_DONE : S_SHIFT;
                  end
`ifdef MULTICYCLE_ALU_MUL_EN
                  OP_MUL: begin
                     res_d    = '0;
                     mcand_d  = a;
                     mplier_d = b;
                     cnt_d    = SHW'(XLEN - 1);
                     state_d  = S_MUL;
                  end
`endif
                  default: begin
                     res_d   = alu_single(op, a, b);
                     state_d = S_DONE;
                  end
               endcase
            end
         end
         S_SHIFT: begin
            amt   = step_amt(cnt_q);
            res_d = shift_by(op_q, res_q, amt);
            cnt_d = cnt_q - amt;
            if (cnt_q == amt) begin
               state_d = S_DONE;
            end
         end
`ifdef MULTICYCLE_ALU_MUL_EN
         S_MUL: begin
            if (mplier_q[0]) begin
               res_d = res_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               state_d = S_DONE;
            end
         end
`endif
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Handshake outputs decoded from the state; result is masked outside DONE.
   always_comb begin
      in_ready  = (state_q == S_IDLE);
      out_valid = (state_q == S_DONE);
      busy      = (state_q != S_IDLE);
      result    = (state_q == S_DONE) ? res_q : '0;
   end

   // State register; only control is reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Operand and working registers; contents are irrelevant until loaded at accept.
   always_ff @(posedge clk) begin
      res_q    <= res_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
`ifdef MULTICYCLE_ALU_MUL_EN
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
`endif
   end

endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu: two instances (SHIFT_STEP 1 and 4).
// Expected results and latencies come from a plain arithmetic reference model.
// Build with MULTICYCLE_ALU_MUL_EN to expect the multiplier on op 11.
module tb_multicycle_alu;

   localparam int XLEN  = 32;
   localparam int STEP0 = 1;
   localparam int STEP1 = 4;
`ifdef MULTICYCLE_ALU_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   typedef struct {
      logic [31:0] res;
      int          acc;
      int          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  in_valid, in_ready, out_valid, out_ready, busy;
   logic [3:0]  op_i [2];
   logic [31:0] a_i  [2];
   logic [31:0] b_i  [2];
   logic [31:0] res_o[2];

   int          cyc   = 0;
   int          total = 0;
   int          bad   = 0;
   exp_t        sb0[$];
   exp_t        sb1[$];
   bit          in_txn[2];
   logic [31:0] held[2];
   int          stall[2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   multicycle_alu #(.XLEN(XLEN), .SHIFT_STEP(STEP0)) u_dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .op(op_i[0]), .a(a_i[0]), .b(b_i[0]), .out_valid(out_valid[0]),
      .out_ready(out_ready[0]), .result(res_o[0]), .busy(busy[0]));

   multicycle_alu #(.XLEN(XLEN), .SHIFT_STEP(STEP1)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .op(op_i[1]), .a(a_i[1]), .b(b_i[1]), .out_valid(out_valid[1]),
      .out_ready(out_ready[1]), .result(res_o[1]), .busy(busy[1]));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference behaviour: result from plain arithmetic, latency from the cycle rules.
   function automatic exp_t ref_model(input int step, input logic [3:0] f,
                                      input logic [31:0] x, input logic [31:0] y);
      exp_t r;
      int   sh;
      logic signed [31:0] sx;
      logic signed [31:0] sy;
      sx    = x;
      sy    = y;
      sh    = int'(y[4:0]);
      r.acc = 0;
      r.lat = 1;
      case (f)
         4'd0:  r.res = x + y;
         4'd1:  r.res = x - y;
         4'd2:  r.res = x & y;
         4'd3:  r.res = x | y;
         4'd4:  r.res = x ^ y;
         4'd6:  r.res = x << sh;
         4'd7:  r.res = x >> sh;
         4'd8:  r.res = $unsigned(sx >>> sh);
         4'd9:  r.res = (sx < sy) ? 32'd1 : 32'd0;
         4'd10: r.res = (x < y) ? 32'd1 : 32'd0;
         4'd11: begin
            if (MUL_EN) begin
               r.res = x * y;
               r.lat = XLEN + 1;
            end else begin
               r.res = 32'd0;
            end
         end
         default: r.res = 32'd0;
      endcase
      if (f == 4'd6 || f == 4'd7 || f == 4'd8) begin
         r.lat = 1 + (sh + step - 1) / step;
      end
      return r;
   endfunction

   task automatic pop_exp(input int k, output exp_t e, output bit ok);
      ok = 1'b0;
      if (k == 0) begin
         if (sb0.size() > 0) begin
            e  = sb0.pop_front();
            ok = 1'b1;
         end
      end else begin
         if (sb1.size() > 0) begin
            e  = sb1.pop_front();
            ok = 1'b1;
         end
      end
   endtask

   // Monitor for one instance: runs every falling edge and drives out_ready.
   task automatic mon(input int k);
      exp_t e;
      bit   ok;
      logic rdy;
      if (rst) begin
         in_txn[k]    = 1'b0;
         out_ready[k] = 1'b0;
         return;
      end
      if (out_valid[k]) begin
         if (!in_txn[k]) begin
            pop_exp(k, e, ok);
            if (!ok) begin
               check($sformatf("unexpected_out%0d", k), res_o[k], 32'hxxxxxxxx);
            end else begin
               check($sformatf("latency%0d", k), 32'(cyc - e.acc), 32'(e.lat));
               check($sformatf("result%0d", k), res_o[k], e.res);
            end
            in_txn[k] = 1'b1;
            held[k]   = res_o[k];
         end else begin
            check($sformatf("result_hold%0d", k), res_o[k], held[k]);
         end
         check($sformatf("in_ready_done%0d", k), 32'(in_ready[k]), 32'd0);
         check($sformatf("busy_done%0d", k), 32'(busy[k]), 32'd1);
         if (stall[k] > 0) begin
            rdy = 1'b0;
            stall[k]--;
         end else begin
            rdy = ($urandom_range(0, 3) != 0);
         end
         if (rdy) in_txn[k] = 1'b0;
      end else begin
         check($sformatf("result_zero%0d", k), res_o[k], 32'd0);
         rdy = 1'($urandom_range(0, 1));
      end
      out_ready[k] = rdy;
   endtask

   always @(negedge clk) begin
      mon(0);
      mon(1);
   end

   // Offer one operation (called at a falling edge); returns the falling edge after accept.
   task automatic issue(input int k, input logic [3:0] f, input logic [31:0] x, input logic [31:0] y);
      exp_t e;
      int   guard;
      e        = ref_model((k == 0) ? STEP0 : STEP1, f, x, y);
      op_i[k]  = f;
      a_i[k]   = x;
      b_i[k]   = y;
      in_valid[k] = 1'b1;
      guard    = 0;
      while (!in_ready[k] && guard < 400) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 400) begin
         check($sformatf("accept_timeout%0d", k), 32'(in_ready[k]), 32'd1);
         in_valid[k] = 1'b0;
         return;
      end
      e.acc = cyc;
      if (k == 0) sb0.push_back(e);
      else        sb1.push_back(e);
      @(negedge clk);
      in_valid[k] = 1'b0;
      op_i[k]  = 4'($urandom);
      a_i[k]   = $urandom;
      b_i[k]   = $urandom;
   endtask

   task automatic wait_idle(input int k);
      int guard;
      guard = 0;
      while (guard < 400 && !(((k == 0) ? sb0.size() : sb1.size()) == 0 && !in_txn[k] && in_ready[k])) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 400) begin
         check($sformatf("idle_timeout%0d", k), 32'(in_ready[k]), 32'd1);
      end
   endtask

   task automatic check_reset(input int k);
      check($sformatf("rst_in_ready%0d", k), 32'(in_ready[k]), 32'd1);
      check($sformatf("rst_out_valid%0d", k), 32'(out_valid[k]), 32'd0);
      check($sformatf("rst_result%0d", k), res_o[k], 32'd0);
      check($sformatf("rst_busy%0d", k), 32'(busy[k]), 32'd0);
   endtask

   // One-cycle reset pulse; anything in flight is discarded.
   task automatic pulse_rst();
      rst = 1'b1;
      sb0.delete();
      sb1.delete();
      in_txn[0] = 1'b0;
      in_txn[1] = 1'b0;
      stall[0]  = 0;
      stall[1]  = 0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   function automatic logic [31:0] rand_word();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      rst      = 1'b1;
      in_valid = 2'b00;
      for (int k = 0; k < 2; k++) begin
         op_i[k]   = 4'd0;
         a_i[k]    = 32'd0;
         b_i[k]    = 32'd0;
         stall[k]  = 0;
         in_txn[k] = 1'b0;
         held[k]   = 32'd0;
      end
      repeat (3) @(negedge clk);
      check_reset(0);
      check_reset(1);
      rst = 1'b0;
      @(negedge clk);

      // Wrap-around add, shifts with sign fill and upper b bits ignored.
      issue(0, 4'd0, 32'hFFFF_FFFF, 32'd1);        wait_idle(0);
      issue(0, 4'd8, 32'h8000_0000, 32'h23);       wait_idle(0);
      issue(0, 4'd7, 32'h8000_0000, 32'h23);       wait_idle(0);
      issue(1, 4'd8, 32'h8000_0000, 32'h23);       wait_idle(1);
      issue(1, 4'd6, 32'd1, 32'd31);               wait_idle(1);
      issue(1, 4'd6, 32'h0000_1234, 32'd0);        wait_idle(1);
      issue(0, 4'd6, 32'h0000_00F1, 32'd31);       wait_idle(0);
      issue(0, 4'd11, 32'hFFFF_FFFF, 32'd3);       wait_idle(0);
      issue(1, 4'd5, 32'h1234_5678, 32'h9ABC_DEF0); wait_idle(1);
      issue(1, 4'd15, 32'h1234_5678, 32'h9ABC_DEF0); wait_idle(1);

      // Signed versus unsigned compare, with the consumer stalling.
      stall[0] = 5;
      issue(0, 4'd9, 32'hFFFF_FFFF, 32'd1);        wait_idle(0);
      stall[0] = 5;
      issue(0, 4'd10, 32'hFFFF_FFFF, 32'd1);       wait_idle(0);

      // Reset during the second cycle of a long operation.
      if (MUL_EN) issue(0, 4'd11, 32'h1234_5678, 32'd7);
      else        issue(0, 4'd6, 32'd1, 32'd31);
      @(negedge clk);
      pulse_rst();
      check_reset(0);
      check_reset(1);
      issue(0, 4'd0, 32'd2, 32'd3);                wait_idle(0);

      // Reset while a result waits in DONE.
      stall[1] = 1000;
      issue(1, 4'd1, 32'd10, 32'd20);
      repeat (2) @(negedge clk);
      pulse_rst();
      check_reset(1);
      issue(1, 4'd0, 32'd2, 32'd3);                wait_idle(1);

      // Random back-to-back traffic on both step sizes.
      for (int i = 0; i < 60; i++) begin
         issue(i % 2, 4'($urandom_range(0, 15)), rand_word(), rand_word());
      end
      wait_idle(0);
      wait_idle(1);
      check("sb0_empty", 32'(sb0.size()), 32'd0);
      check("sb1_empty", 32'(sb1.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; port names SHALL be clk and rst.
REQ-002 Parameter XLEN, default 32, SHALL set the operand and result width, with XLEN a power of 2 and at least 8.
REQ-003 Parameter SHIFT_STEP, default 1, SHALL set the maximum shift bits applied per cycle, with SHIFT_STEP a power of 2 and at most XLEN.
REQ-004 Ports SHALL be, in this order:
- clk  input  1  clock
- rst  input  1  sync active-high reset
- in_valid  input  1  operation offered
- in_ready  output  1  block accepts an operation
- op  input  4  operation code
- a  input  XLEN  operand A (rs1)
- b  input  XLEN  operand B (rs2 or immediate)
- out_valid  output  1  result available
- out_ready  input  1  consumer takes the result
- result  output  XLEN  operation result
- busy  output  1  state is not IDLE

Function
REQ-005 op encoding SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOP, 6 SLL, 7 SRL, 8 SRA, 9 SLT, 10 SLTU, 11 MUL.
- All other codes are undefined.
REQ-006 The FSM SHALL have exactly four states: IDLE, SHIFT, MUL, DONE.
REQ-007 in_ready SHALL be 1 only in IDLE; an operation is accepted on a cycle with in_valid and in_ready both 1.
- a, b and op SHALL be captured at accept; later input changes SHALL have no effect.
REQ-008 On accept, ADD, SUB, AND, OR, XOR, SLT and SLTU SHALL go IDLE->DONE, with result valid the next cycle (latency 1).
- Arithmetic is modulo 2^XLEN.
- SLT is signed and SLTU unsigned; both return 1 or 0, zero-extended.
REQ-009 NOP and undefined codes SHALL go IDLE->DONE with result 0.
REQ-010 Shift amount SHALL be b[log2(XLEN)-1:0]; upper bits of b are ignored.
REQ-011 SLL/SRL/SRA SHALL go to SHIFT and apply min(SHIFT_STEP, remaining) bits per cycle, then go to DONE.
- Latency SHALL be 1 + ceil(shamt/SHIFT_STEP).
- shamt 0 SHALL go directly to DONE with result = a (latency 1).
REQ-012 SRA SHALL replicate a[XLEN-1]; SRL and SLL SHALL fill with zeros.
REQ-013 MUL (when compiled in) SHALL run XLEN shift-add iterations in state MUL.
- Result SHALL be the low XLEN bits of a*b; latency XLEN+1.
REQ-014 In DONE, out_valid SHALL be 1 and result SHALL hold stable until out_ready is 1.
- When out_valid and out_ready are both 1, the FSM SHALL return to IDLE on the next cycle.
- No new operation SHALL be accepted in that same cycle.
REQ-015 result SHALL be 0 whenever out_valid is 0.
REQ-016 busy SHALL equal (state != IDLE).

Reset
REQ-017 When rst is 1 at a clock edge, state SHALL become IDLE, with in_ready=1, out_valid=0, result=0 and busy=0.
REQ-018 A reset asserted mid-SHIFT, mid-MUL or in DONE SHALL abort the operation and discard its result.
REQ-019 rst SHALL take priority over in_valid on the same edge.

Configuration
REQ-020 With macro MULTICYCLE_ALU_MUL_EN defined, op 11 SHALL behave per REQ-013.
REQ-021 Without MULTICYCLE_ALU_MUL_EN, op 11 SHALL behave as an undefined code (result 0, latency 1), and state MUL and its datapath SHALL be absent.

Verification
REQ-022 XLEN=32: ADD a=0xFFFFFFFF, b=1, out_ready=1 -> out_valid 1 cycle after accept, result=0x00000000.
REQ-023 XLEN=32, SHIFT_STEP=1: SRA a=0x80000000, b=0x23 (shamt 3) -> result=0xF0000000, latency 4; SRL of the same operands -> 0x10000000.
REQ-024 XLEN=32, SHIFT_STEP=4: SLL a=1, b=31 -> result=0x80000000, latency 9; SLL with b=0 -> result=a, latency 1.
REQ-025 MUL_EN defined: MUL a=0xFFFFFFFF, b=3 -> result=0xFFFFFFFD, latency 33; MUL_EN undefined: op 11 -> result=0, latency 1.
REQ-026 SLT a=0xFFFFFFFF, b=1 -> 1, and SLTU with the same operands -> 0, with out_ready held 0 for 5 cycles -> result stable and in_ready=0 throughout.
REQ-027 rst pulsed during cycle 2 of MUL -> next cycle in_ready=1, out_valid=0, result=0; a following ADD 2+3 -> 5.
